eq_stream_collector: RTL



---
 rtl/eq_pkg.sv | 22 ++
 rtl/eq_out_buffer.sv | 55 +++++
 rtl/eq_stream_collector.sv | 136 +++++++++++++
 3 files changed

// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - shared types, constants and helpers for the equation stream collector
package eq_pkg;
   localparam int EQ_WIDTH     = 32;
   localparam int EQ_SEQ_W     = 8;
   localparam int CORE_LATENCY = 4;

   typedef struct packed {
      logic signed [EQ_WIDTH-1:0] a;
      logic signed [EQ_WIDTH-1:0] b;
      logic signed [EQ_WIDTH-1:0] c;
      logic signed [EQ_WIDTH-1:0] d;
   } eq_args_t;

   typedef struct packed {
      logic [EQ_WIDTH-1:0] data;
      logic [EQ_SEQ_W-1:0] seq;
   } eq_res_t;

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/eq_out_buffer.sv
// rtl/eq_out_buffer.sv - show-ahead result FIFO with full/empty flags and flush on rst
module eq_out_buffer
   import eq_pkg::*;
#(
   parameter type T     = eq_res_t,
   parameter int  DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic push_i,
   input  T     push_data_i,
   input  logic pop_i,
   output T     head_o,
   output logic full_o,
   output logic empty_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_width(DEPTH);

   T              mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Head reads as zero when empty so the outputs have a defined reset value
   always_comb begin
      head_o = '0;
      if (!empty_o) head_o = mem_q[rd_ptr_q];
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/eq_stream_collector.sv
// rtl/eq_stream_collector.sv - credit-gated front end and result collector for the equation core
// Optional watchdog enabled by defining EQ_COLLECT_TIMEOUT_EN.
module eq_stream_collector
   import eq_pkg::*;
#(
   parameter int WIDTH   = EQ_WIDTH,
   parameter int DEPTH   = 4,
   parameter int SEQ_W   = EQ_SEQ_W,
   parameter int TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_vld,
   output logic                    in_rdy,
   input  logic signed [WIDTH-1:0] in_a,
   input  logic signed [WIDTH-1:0] in_b,
   input  logic signed [WIDTH-1:0] in_c,
   input  logic signed [WIDTH-1:0] in_d,
   output logic                    eq_arg_vld,
   output logic signed [WIDTH-1:0] eq_a,
   output logic signed [WIDTH-1:0] eq_b,
   output logic signed [WIDTH-1:0] eq_c,
   output logic signed [WIDTH-1:0] eq_d,
   input  logic                    eq_res_vld,
   input  logic        [WIDTH-1:0] eq_res,
   output logic                    out_vld,
   input  logic                    out_rdy,
   output logic        [WIDTH-1:0] out_data,
   output logic        [SEQ_W-1:0] out_seq,
   output logic                    idle,
   output logic                    err
);
   localparam int CW = cnt_width(DEPTH);

   typedef struct packed {
      logic signed [WIDTH-1:0] a;
      logic signed [WIDTH-1:0] b;
      logic signed [WIDTH-1:0] c;
      logic signed [WIDTH-1:0] d;
   } args_t;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SEQ_W-1:0] seq;
   } res_t;

   logic [CW-1:0]    credits_q, credits_d, inflight_q, inflight_d;
   logic [SEQ_W-1:0] seq_q, seq_d;
   logic             in_rdy_q, arg_vld_q, err_q, err_d;
   args_t            args_q;
   logic             accept, pop, res_ok, push, drop, buf_full, buf_empty, wdog_hit;
   res_t             push_data, head;

`ifdef EQ_COLLECT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] wdog_q, wdog_d;

   always_comb begin
      wdog_d = wdog_q;
      if (eq_res_vld || (inflight_q == '0)) wdog_d = '0;
      else if (wdog_q != TW'(TIMEOUT))      wdog_d = wdog_q + TW'(1);
   end

   assign wdog_hit = (wdog_q == TW'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (rst) wdog_q <= '0;
      else     wdog_q <= wdog_d;
   end
`else
   localparam int timeout_unused = TIMEOUT;
   assign wdog_hit = 1'b0;
`endif

   // in_rdy_q mirrors credits!=0; rst gating keeps it low during the reset cycle itself
   assign in_rdy    = in_rdy_q & ~rst;
   assign accept    = in_vld & in_rdy;
   assign out_vld   = ~buf_empty;
   assign pop       = out_vld & out_rdy;
   assign res_ok    = eq_res_vld & (inflight_q != '0);
   assign push      = res_ok & ~buf_full;
   assign drop      = eq_res_vld & ~push;
   assign push_data = '{data: eq_res, seq: seq_q};

   always_comb begin
      credits_d = credits_q;
      if (accept && !pop)      credits_d = credits_q - CW'(1);
      else if (pop && !accept) credits_d = credits_q + CW'(1);
      inflight_d = inflight_q;
      if (arg_vld_q && !res_ok)      inflight_d = inflight_q + CW'(1);
      else if (res_ok && !arg_vld_q) inflight_d = inflight_q - CW'(1);
      seq_d = push ? seq_q + SEQ_W'(1) : seq_q;
      err_d = err_q | drop | wdog_hit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         credits_q  <= CW'(DEPTH);
         inflight_q <= '0;
         in_rdy_q   <= 1'b1;
         arg_vld_q  <= 1'b0;
         args_q     <= '0;
         seq_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         credits_q  <= credits_d;
         inflight_q <= inflight_d;
         in_rdy_q   <= (credits_d != '0);
         arg_vld_q  <= accept;
         if (accept) args_q <= '{a: in_a, b: in_b, c: in_c, d: in_d};
         seq_q      <= seq_d;
         err_q      <= err_d;
      end
   end

   eq_out_buffer #(.T(res_t), .DEPTH(DEPTH)) u_buf (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (pop),
      .head_o      (head),
      .full_o      (buf_full),
      .empty_o     (buf_empty)
   );

   assign eq_arg_vld = arg_vld_q;
   assign eq_a       = args_q.a;
   assign eq_b       = args_q.b;
   assign eq_c       = args_q.c;
   assign eq_d       = args_q.d;
   assign out_data   = head.data;
   assign out_seq    = head.seq;
   assign idle       = (inflight_q == '0) & buf_empty & ~arg_vld_q;
   assign err        = err_q;
endmodule
